// File: rtl/wvb_rd_ctrl.sv
// Waveform buffer read controller: streams one header-described event out of the
// buffer through a credit-limited skid FIFO, then pops the header.
module wvb_rd_ctrl #(
    parameter int P_ADR_WIDTH  = 12,
    parameter int P_DATA_WIDTH = 22,
    parameter int P_RD_LAT     = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    hdr_empty,
    input  logic [P_ADR_WIDTH-1:0]  hdr_start_addr,
    input  logic [P_ADR_WIDTH-1:0]  hdr_stop_addr,
    output logic                    hdr_rdreq,
    output logic [P_ADR_WIDTH-1:0]  wvb_rd_addr,
    input  logic [P_DATA_WIDTH-1:0] wvb_rd_data,
    output logic                    wvb_rddone,
    output logic [P_ADR_WIDTH:0]    evt_len,
    output logic [P_DATA_WIDTH-1:0] dout_data,
    output logic                    dout_valid,
    output logic                    dout_first,
    output logic                    dout_last,
    input  logic                    dout_ready
);
    localparam int LW = P_ADR_WIDTH + 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]             state_q, state_d;
    logic [P_ADR_WIDTH-1:0] addr_q, addr_d;
    logic [LW-1:0]          len_q, len_d;
    logic [LW-1:0]          issued_q, issued_d;
    logic [P_ADR_WIDTH-1:0] span;

    logic [P_RD_LAT-1:0]    vld_pipe_q, first_pipe_q, last_pipe_q;

    logic [P_DATA_WIDTH-1:0] skid_data_q [4];
    logic [3:0]              skid_first_q, skid_last_q;
    logic [1:0]              wr_ptr_q, rd_ptr_q;
    logic [2:0]              skid_cnt_q;

    logic [2:0] in_flight;
    logic       issue, push, pop, tag_first, tag_last;

    assign span = hdr_stop_addr - hdr_start_addr;

    always_comb begin
        in_flight = 3'd0;
        for (int k = 0; k < P_RD_LAT; k++) begin
            in_flight = in_flight + 3'(vld_pipe_q[k]);
        end
    end

    // Credits cover both reads still in the RAM pipe and words parked in the skid,
    // so every returning word is guaranteed a slot.
    assign issue     = (state_q == S_STREAM) &&
                       (({1'b0, in_flight} + {1'b0, skid_cnt_q}) < 4'd4);
    assign tag_first = (issued_q == '0);
    assign tag_last  = (issued_q == (len_q - LW'(1)));
    assign push      = vld_pipe_q[P_RD_LAT-1];
    assign pop       = dout_valid && dout_ready;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        len_d    = len_q;
        issued_d = issued_q;
        case (state_q)
            S_IDLE: begin
                if (en && !hdr_empty) begin
                    addr_d   = hdr_start_addr;
                    len_d    = {1'b0, span} + LW'(1);
                    issued_d = '0;
                    state_d  = S_STREAM;
                end
            end
            S_STREAM: begin
                if (issue) begin
                    addr_d   = addr_q + P_ADR_WIDTH'(1);
                    issued_d = issued_q + LW'(1);
                    if (tag_last) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && dout_last) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            len_q        <= '0;
            issued_q     <= '0;
            vld_pipe_q   <= '0;
            first_pipe_q <= '0;
            last_pipe_q  <= '0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            len_q           <= len_d;
            issued_q        <= issued_d;
            vld_pipe_q[0]   <= issue;
            first_pipe_q[0] <= issue && tag_first;
            last_pipe_q[0]  <= issue && tag_last;
            for (int k = 1; k < P_RD_LAT; k++) begin
                vld_pipe_q[k]   <= vld_pipe_q[k-1];
                first_pipe_q[k] <= first_pipe_q[k-1];
                last_pipe_q[k]  <= last_pipe_q[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            skid_cnt_q   <= '0;
            skid_first_q <= '0;
            skid_last_q  <= '0;
            for (int i = 0; i < 4; i++) skid_data_q[i] <= '0;
        end else begin
            if (push) begin
                skid_data_q[wr_ptr_q]  <= wvb_rd_data;
                skid_first_q[wr_ptr_q] <= first_pipe_q[P_RD_LAT-1];
                skid_last_q[wr_ptr_q]  <= last_pipe_q[P_RD_LAT-1];
                wr_ptr_q               <= wr_ptr_q + 2'd1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
            case ({push, pop})
                2'b10:   skid_cnt_q <= skid_cnt_q + 3'd1;
                2'b01:   skid_cnt_q <= skid_cnt_q - 3'd1;
                default: skid_cnt_q <= skid_cnt_q;
            endcase
        end
    end

    assign dout_valid  = (skid_cnt_q != 3'd0);
    assign dout_data   = dout_valid ? skid_data_q[rd_ptr_q] : '0;
    assign dout_first  = dout_valid && skid_first_q[rd_ptr_q];
    assign dout_last   = dout_valid && skid_last_q[rd_ptr_q];
    assign wvb_rd_addr = addr_q;
    assign evt_len     = len_q;
    assign wvb_rddone  = (state_q == S_DONE);
    assign hdr_rdreq   = (state_q == S_DONE);

endmodule

// File: tb/tb_wvb_rd_ctrl.sv
// Bench for wvb_rd_ctrl: RAM and header FIFO models plus an event-level scoreboard
// that checks every accepted word, the done/pop pulses and handshake stability.
module tb_wvb_rd_ctrl;
    localparam int AW = 12;
    localparam int DW = 22;
    localparam int N  = 4096;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          hdr_empty = 1'b1;
    logic [AW-1:0] hdr_start_addr = '0;
    logic [AW-1:0] hdr_stop_addr = '0;
    logic          hdr_rdreq;
    logic [AW-1:0] wvb_rd_addr;
    logic [DW-1:0] wvb_rd_data;
    logic          wvb_rddone;
    logic [AW:0]   evt_len;
    logic [DW-1:0] dout_data;
    logic          dout_valid, dout_first, dout_last;
    logic          dout_ready = 1'b0;

    wvb_rd_ctrl #(.P_ADR_WIDTH(AW), .P_DATA_WIDTH(DW), .P_RD_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .hdr_empty(hdr_empty),
        .hdr_start_addr(hdr_start_addr), .hdr_stop_addr(hdr_stop_addr),
        .hdr_rdreq(hdr_rdreq), .wvb_rd_addr(wvb_rd_addr), .wvb_rd_data(wvb_rd_data),
        .wvb_rddone(wvb_rddone), .evt_len(evt_len), .dout_data(dout_data),
        .dout_valid(dout_valid), .dout_first(dout_first), .dout_last(dout_last),
        .dout_ready(dout_ready)
    );

    always #5 clk = ~clk;

    // Two-cycle-latency buffer model
    logic [DW-1:0] ram [N];
    logic [DW-1:0] rd1 = '0, rd2 = '0;
    assign wvb_rd_data = rd2;
    always @(posedge clk) begin
        rd1 <= ram[wvb_rd_addr];
        rd2 <= rd1;
    end

    int passed = 0, total = 0;
    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    logic [AW-1:0] hq_start[$], hq_stop[$];
    task automatic hdr_refresh();
        hdr_empty      = (hq_start.size() == 0);
        hdr_start_addr = hdr_empty ? '0 : hq_start[0];
        hdr_stop_addr  = hdr_empty ? '0 : hq_stop[0];
    endtask
    task automatic push_hdr(input logic [AW-1:0] s, input logic [AW-1:0] e);
        hq_start.push_back(s);
        hq_stop.push_back(e);
        hdr_refresh();
    endtask

    function automatic int mlen(input logic [AW-1:0] s, input logic [AW-1:0] e);
        logic [AW-1:0] d;
        d = e - s;
        return int'(d) + 1;
    endfunction

    int  word_idx = 0, done_cnt = 0, rst_edges = 0, cyc = 0;
    int  first_cyc = 0, last_cyc = 0, ev_words = 0, rmode = 0;
    bit  done_due = 0, pop_pending = 0, hold = 0;
    logic [DW-1:0] hold_data = '0, first_data = '0, last_data = '0;
    bit  hold_first = 0, hold_last = 0;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) rst_edges++;
        else rst_edges = 0;
        #1;
        if (pop_pending) begin
            void'(hq_start.pop_front());
            void'(hq_stop.pop_front());
            hdr_refresh();
            pop_pending = 0;
        end
        if (rmode == 0) dout_ready = 1'b1;
        else if ((cyc % 37) < 10) dout_ready = 1'b0;
        else dout_ready = 1'($urandom_range(0, 1));
    end

    // Scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            word_idx = 0;
            done_due = 0;
            hold     = 0;
            if (rst_edges > 0) begin
                chk("rst_valid", dout_valid, 0);
                chk("rst_data", dout_data, 0);
                chk("rst_first", dout_first, 0);
                chk("rst_last", dout_last, 0);
                chk("rst_rddone", wvb_rddone, 0);
                chk("rst_rdreq", hdr_rdreq, 0);
                chk("rst_evt_len", evt_len, 0);
                chk("rst_addr", wvb_rd_addr, 0);
            end
        end else begin
            chk("rddone", wvb_rddone, done_due);
            chk("rdreq", hdr_rdreq, done_due);
            done_due = 0;
            if (hold) begin
                chk("hold_valid", dout_valid, 1);
                chk("hold_data", dout_data, hold_data);
                chk("hold_first", dout_first, hold_first);
                chk("hold_last", dout_last, hold_last);
            end
            hold = dout_valid && !dout_ready;
            hold_data = dout_data; hold_first = dout_first; hold_last = dout_last;
            if (dout_valid && dout_ready) begin
                if (hq_start.size() == 0) begin
                    total++;
                    $display("FAIL spurious_word: data %0h with no header queued", dout_data);
                end else begin
                    automatic int len = mlen(hq_start[0], hq_stop[0]);
                    automatic logic [AW-1:0] a = hq_start[0] + AW'(word_idx);
                    chk("word_data", dout_data, ram[a]);
                    chk("word_first", dout_first, word_idx == 0);
                    chk("word_last", dout_last, word_idx == len - 1);
                    chk("evt_len", evt_len, len);
                    if (word_idx == 0) begin first_cyc = cyc; first_data = dout_data; end
                    if (word_idx == len - 1) begin
                        done_due  = 1;
                        last_cyc  = cyc;
                        last_data = dout_data;
                        ev_words  = word_idx + 1;
                        word_idx  = 0;
                    end else begin
                        word_idx++;
                    end
                end
            end
            if (wvb_rddone) begin
                done_cnt++;
                pop_pending = 1;
            end
        end
    end

    task automatic wait_done(input int target, input int budget, input string name);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        chk(name, done_cnt, target);
    endtask

    initial begin
        for (int i = 0; i < N; i++) ram[i] = DW'($urandom);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_valid", dout_valid, 0);
        chk("reset_rdreq", hdr_rdreq, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        en    = 1'b1;

        // single event
        push_hdr(12'h010, 12'h013);
        wait_done(1, 100, "t1_done");
        chk("t1_len", evt_len, 4);
        chk("t1_words", ev_words, 4);
        chk("t1_burst", last_cyc - first_cyc, 3);
        chk("t1_word0", first_data, ram[12'h010]);

        // wrap-around
        push_hdr(12'hFFE, 12'h001);
        wait_done(2, 100, "t2_done");
        chk("t2_len", evt_len, 4);
        chk("t2_first", first_data, ram[12'hFFE]);
        chk("t2_last", last_data, ram[12'h001]);

        // full buffer, then single word
        push_hdr(12'h100, 12'h0FF);
        wait_done(3, 5000, "t3a_done");
        chk("t3a_len", evt_len, 4096);
        chk("t3a_words", ev_words, 4096);
        chk("t3a_burst", last_cyc - first_cyc, 4095);
        push_hdr(12'h020, 12'h020);
        wait_done(4, 100, "t3b_done");
        chk("t3b_len", evt_len, 1);
        chk("t3b_words", ev_words, 1);
        chk("t3b_data", first_data, ram[12'h020]);

        // backpressure with stalls; en dropped mid-event
        rmode = 1;
        push_hdr(12'h200, 12'h20F);
        for (int n = 0; n < 200 && word_idx == 0; n++) @(negedge clk);
        en = 1'b0;
        wait_done(5, 2000, "t4_done");
        chk("t4_len", evt_len, 16);
        chk("t4_words", ev_words, 16);
        rmode = 0;

        // three queued headers held off by en=0
        push_hdr(12'h300, 12'h302);
        push_hdr(12'h310, 12'h317);
        push_hdr(12'hFFF, 12'h000);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("en0_valid", dout_valid, 0);
        chk("en0_done_cnt", done_cnt, 5);
        chk("en0_hdr_kept", hq_start.size(), 3);
        @(posedge clk); #1;
        en = 1'b1;
        wait_done(8, 300, "t5_done");
        chk("t5_len", evt_len, 2);
        chk("t5_hdr_empty", hq_start.size(), 0);

        // reset after 5 of 10 words
        push_hdr(12'h400, 12'h409);
        for (int n = 0; n < 200 && word_idx < 5; n++) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("t6_valid", dout_valid, 0);
        chk("t6_rddone", wvb_rddone, 0);
        chk("t6_hdr_kept", hq_start.size(), 1);
        chk("t6_done_cnt", done_cnt, 8);
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_done(9, 200, "t6_done");
        chk("t6_len", evt_len, 10);
        chk("t6_words", ev_words, 10);
        chk("t6_first", first_data, ram[12'h400]);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
